conv_encoder_core: RTL

CONV_ENCODER_CORE -- requirements
Module: conv_encoder_core

---
 rtl/conv_encoder_core.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_core.sv
// rtl/conv_encoder_core.sv - rate 1/N_OUT convolutional encoder with CtrlPort registers and stream I/O
//
// Ports:
//   ce_clk, ce_rst_n      single clock, synchronous active-low reset
//   s_ctrlport_*          register access; ack and read data one cycle after a request
//   s_axis_*              input items, MSB of each item encoded first
//   m_axis_*              coded output items, first coded bit in the MSB of each item
//
// Registers: 0x00 CTRL[0]=bypass CTRL[1]=tail_en, 0x04+4*j POLY_j[8:0], 0x20 PKT_CNT (RO).
module conv_encoder_core #(
  parameter int                   ITEM_W = 8,
  parameter int                   K      = 7,
  parameter int                   N_OUT  = 2,
  parameter logic [N_OUT*9-1:0]   G_INIT = {9'o133, 9'o171}
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [ITEM_W-1:0] m_axis_tdata,
  output logic              m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  // The accumulator keeps pending coded bits right-aligned, oldest bit highest.
  // It must hold up to ITEM_W-1 leftover bits plus one fresh group of N_OUT bits.
  localparam int AW = ITEM_W + N_OUT;
  localparam int CW = $clog2(AW + 1);
  localparam int BW = $clog2(ITEM_W + 1);
  localparam int TW = $clog2(K);

  localparam logic [BW-1:0] BIT_LAST  = BW'(ITEM_W - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);
  localparam logic [CW-1:0] ITEM_CW   = CW'(ITEM_W);
  localparam logic [CW-1:0] NOUT_CW   = CW'(N_OUT);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, PAD} state_t;

  state_t            state;
  logic [K-2:0]      sr;
  logic [ITEM_W-1:0] item_reg;
  logic              last_reg;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     tail_cnt;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     acc_cnt;
  logic              rdy_en;
  logic [31:0]       pkt_cnt;

  // Written registers land in the shadow copies; the active copies follow
  // them only while idle so a packet never sees a mid-stream change.
  logic [1:0]        ctrl_sh;
  logic [1:0]        ctrl_act;
  logic [8:0]        poly_sh  [N_OUT];
  logic [K-1:0]      poly_act [N_OUT];

  logic              bypass;
  logic              tail_en;
  logic              in_bit;
  logic [K-1:0]      r;
  logic [N_OUT-1:0]  coded;
  logic [AW-1:0]     acc_app;
  logic [CW-1:0]     cnt_app;
  logic              word_done;
  logic [ITEM_W-1:0] word_app;
  logic [ITEM_W-1:0] pad_word;
  logic              out_free;
  logic              encoding;
  logic              stall;
  logic              step;
  logic              item_end;
  logic              final_bit;
  logic              in_hs;
  logic [31:0]       rd_val;
  logic              unused_data;

  assign unused_data = ^s_ctrlport_req_data[31:9];
  assign m_axis_tkeep = 1'b1;

  assign bypass    = ctrl_act[0];
  assign tail_en   = ctrl_act[1];
  assign in_bit    = (state == SHIFT) ? item_reg[ITEM_W-1] : 1'b0;
  assign r         = {in_bit, sr};

  // c_0 is the first bit of the group in the stream, so it takes the top slot.
  always_comb begin
    coded = '0;
    for (int j = 0; j < N_OUT; j++) begin
      coded[N_OUT-1-j] = ^(r & poly_act[j]);
    end
  end

  assign acc_app   = (acc << N_OUT) | AW'(coded);
  assign cnt_app   = acc_cnt + NOUT_CW;
  assign word_done = (cnt_app >= ITEM_CW);
  assign word_app  = ITEM_W'(acc_app >> (cnt_app - ITEM_CW));
  assign pad_word  = ITEM_W'(acc << (ITEM_CW - acc_cnt));

  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign encoding  = (state == SHIFT) || (state == TAIL);
  // A bit is only consumed when any word it completes has somewhere to go.
  assign stall     = encoding && word_done && !out_free;
  assign step      = encoding && !stall;
  assign item_end  = (state == SHIFT) && (bit_cnt == BIT_LAST);
  assign final_bit = (item_end && last_reg && !tail_en) ||
                     ((state == TAIL) && (tail_cnt == TAIL_LAST));

  assign s_axis_tready = rdy_en &&
                         (((state == IDLE) && (!bypass || out_free)) ||
                          (item_end && !last_reg && !stall));
  assign in_hs = s_axis_tvalid && s_axis_tready;

  always_comb begin
    rd_val = '0;
    if (s_ctrlport_req_addr == 20'h00) rd_val = {30'b0, ctrl_sh};
    if (s_ctrlport_req_addr == 20'h20) rd_val = pkt_cnt;
    for (int j = 0; j < N_OUT; j++) begin
      if (s_ctrlport_req_addr == 20'(4 + 4 * j)) rd_val = {23'b0, poly_sh[j]};
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      state                <= IDLE;
      sr                   <= '0;
      item_reg             <= '0;
      last_reg             <= 1'b0;
      bit_cnt              <= '0;
      tail_cnt             <= '0;
      acc                  <= '0;
      acc_cnt              <= '0;
      rdy_en               <= 1'b0;
      pkt_cnt              <= '0;
      m_axis_tvalid        <= 1'b0;
      m_axis_tlast         <= 1'b0;
      m_axis_tdata         <= '0;
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
      ctrl_sh              <= 2'b10;
      ctrl_act             <= 2'b10;
      for (int j = 0; j < N_OUT; j++) begin
        poly_sh[j]  <= G_INIT[j*9 +: 9];
        poly_act[j] <= G_INIT[j*9 +: K];
      end
    end else begin
      // tready stays low for the first cycle out of reset.
      rdy_en               <= 1'b1;
      s_ctrlport_resp_ack  <= s_ctrlport_req_rd || s_ctrlport_req_wr;
      s_ctrlport_resp_data <= s_ctrlport_req_rd ? rd_val : 32'b0;

      if (s_ctrlport_req_wr) begin
        if (s_ctrlport_req_addr == 20'h00) ctrl_sh <= s_ctrlport_req_data[1:0];
        for (int j = 0; j < N_OUT; j++) begin
          if (s_ctrlport_req_addr == 20'(4 + 4 * j)) poly_sh[j] <= s_ctrlport_req_data[8:0];
        end
      end

      if (state == IDLE) begin
        ctrl_act <= ctrl_sh;
        for (int j = 0; j < N_OUT; j++) poly_act[j] <= poly_sh[j][K-1:0];
      end

      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (in_hs) begin
            if (bypass) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tlast  <= s_axis_tlast;
            end else begin
              item_reg <= s_axis_tdata;
              last_reg <= s_axis_tlast;
              bit_cnt  <= '0;
              state    <= SHIFT;
            end
          end
        end

        SHIFT, TAIL: begin
          if (step) begin
            sr  <= r[K-1:1];
            acc <= acc_app;
            if (word_done) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= word_app;
              // A packet ending exactly on a word boundary tags that word now;
              // PAD then finds the accumulator empty and emits nothing.
              m_axis_tlast  <= final_bit && (cnt_app == ITEM_CW);
              acc_cnt       <= cnt_app - ITEM_CW;
            end else begin
              acc_cnt <= cnt_app;
            end

            if (state == SHIFT) begin
              item_reg <= item_reg << 1;
              bit_cnt  <= bit_cnt + 1'b1;
              if (item_end) begin
                if (last_reg) begin
                  tail_cnt <= '0;
                  state    <= tail_en ? TAIL : PAD;
                end else if (in_hs) begin
                  item_reg <= s_axis_tdata;
                  last_reg <= s_axis_tlast;
                  bit_cnt  <= '0;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
              if (tail_cnt == TAIL_LAST) state <= PAD;
            end
          end
        end

        PAD: begin
          if (acc_cnt == '0) begin
            sr    <= '0;
            state <= IDLE;
          end else if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pad_word;
            m_axis_tlast  <= 1'b1;
            acc_cnt       <= '0;
            sr            <= '0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
